// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and grant encodings for mem_port_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  // Counter width for a latency of lat cycles; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational IF/LS grant select
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (fair alternation on conflict).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic last_gnt,
  output logic gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = GNT_IF;
    if (if_req && ls_req) begin
      gnt = ~last_gnt;
    end else if (ls_req) begin
      gnt = GNT_LS;
    end
  end
`else
  logic w_unused_last_gnt;
  assign w_unused_last_gnt = last_gnt;

  always_comb begin
    gnt = GNT_IF;
    if (ls_req) begin
      gnt = GNT_LS;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between IF and LS
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin instead of LS priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wstrb,
  output logic                  ls_ready,
  output logic                  ls_rvalid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_gnt;
  logic                r_mem_en;
  logic [STRB_W-1:0]   r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_ready;
  logic                r_ls_ready;
  logic                r_if_rvalid;
  logic                r_ls_rvalid;
  logic                w_last_gnt;
  logic                w_pick;
  logic                w_any_req;
  logic                w_decide;
  logic                w_rvalid_next;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_gnt;
  assign w_last_gnt = r_last_gnt;
`else
  assign w_last_gnt = GNT_IF;
`endif

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .ls_req   (ls_req),
    .last_gnt (w_last_gnt),
    .gnt      (w_pick)
  );

  assign w_any_req = if_req | ls_req;
  // Arbitration happens from IDLE and on the data-return cycle, so back-to-back accesses need no idle gap.
  assign w_decide  = (r_state == IDLE) || ((r_state == WAIT) && (r_cnt == '0));
  assign w_rvalid_next = ((r_state == ISSUE) && (CNT_INIT == '0)) ||
                         ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gnt       <= GNT_IF;
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_ls_ready  <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_gnt  <= GNT_IF;
`endif
    end else begin
      r_mem_en    <= 1'b0;
      r_if_ready  <= 1'b0;
      r_ls_ready  <= 1'b0;
      r_if_rvalid <= w_rvalid_next && (r_gnt == GNT_IF);
      r_ls_rvalid <= w_rvalid_next && (r_gnt == GNT_LS);
      if (w_decide && w_any_req) begin
        r_state     <= ISSUE;
        r_gnt       <= w_pick;
        r_mem_en    <= 1'b1;
        r_if_ready  <= (w_pick == GNT_IF);
        r_ls_ready  <= (w_pick == GNT_LS);
        r_mem_addr  <= (w_pick == GNT_LS) ? ls_addr : if_addr;
        r_mem_wdata <= (w_pick == GNT_LS) ? ls_wdata : '0;
        r_mem_we    <= ((w_pick == GNT_LS) && ls_we) ? ls_wstrb : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        r_last_gnt  <= w_pick;
`endif
      end else if (w_decide) begin
        r_state <= IDLE;
      end else if (r_state == ISSUE) begin
        r_state <= WAIT;
        r_cnt   <= CNT_INIT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign if_ready  = r_if_ready;
  assign ls_ready  = r_ls_ready;
  assign if_rvalid = r_if_rvalid;
  assign ls_rvalid = r_ls_rvalid;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench, one arbiter per MEM_LAT of 1, 2 and 3
// Expected grant order follows MEM_ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;

  logic [3:1]  if_ready, if_rvalid, ls_ready, ls_rvalid, mem_en, busy;
  logic [31:0] if_rdata [1:3];
  logic [31:0] ls_rdata [1:3];
  logic [31:0] mem_addr [1:3];
  logic [31:0] mem_wdata [1:3];
  logic [31:0] mem_rdata [1:3];
  logic [3:0]  mem_we [1:3];

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_lat
    logic [31:0] mem  [0:127];
    logic [31:0] pipe [0:2];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready[g]),
      .if_rvalid (if_rvalid[g]),
      .if_rdata  (if_rdata[g]),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_wstrb  (ls_wstrb),
      .ls_ready  (ls_ready[g]),
      .ls_rvalid (ls_rvalid[g]),
      .ls_rdata  (ls_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );

    initial begin
      for (int i = 0; i < 128; i++) begin
        mem[i] = (i == 16) ? 32'h0050_0093 : (32'hA5A5_0000 | (i << 2));
      end
    end

    // Read data emerges exactly g cycles after mem_en; any other cycle shows a poison word.
    always @(posedge clk) begin
      pipe[0] <= mem_en[g] ? mem[mem_addr[g][8:2]] : 32'hBAD0_BAD0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (mem_en[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[g][b]) mem[mem_addr[g][8:2]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
        end
      end
    end

    assign mem_rdata[g] = pipe[g-1];
  end

  always @(negedge clk) begin
    if (((if_ready & ls_ready) != 3'b000) || ((if_rvalid & ls_rvalid) != 3'b000)) viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    while (busy !== 3'b000 && n < 30) begin
      step();
      n++;
    end
    check_eq("idle_timeout", {29'd0, busy}, 32'd0);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic ls_txn_lat1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [3:0] exp_we,
                             input logic chk_rd, input logic [31:0] exp_rd);
    ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_wstrb = strb;
    step();
    check_eq("ls_ready", {31'd0, ls_ready[1]}, 32'd1);
    check_eq("ls_mem_en", {31'd0, mem_en[1]}, 32'd1);
    check_eq("ls_mem_we", {28'd0, mem_we[1]}, {28'd0, exp_we});
    check_eq("ls_mem_addr", mem_addr[1], addr);
    check_eq("ls_mem_wdata", mem_wdata[1], wdata);
    ls_req = 1'b0;
    step();
    check_eq("ls_rvalid", {31'd0, ls_rvalid[1]}, 32'd1);
    if (chk_rd) check_eq("ls_rdata", ls_rdata[1], exp_rd);
    wait_idle();
  endtask

  initial begin
    logic [2:0]  exp_ls_seq;
    logic        seen;
    int          nrdy, nrv;

    ls_we = 1'b0; ls_wdata = '0; ls_wstrb = '0;
    rstn = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h40; ls_addr = 32'h20;
    step();
    step();
    check_eq("rst_busy", {29'd0, busy}, 32'd0);
    check_eq("rst_ready", {29'd0, if_ready | ls_ready}, 32'd0);
    check_eq("rst_rvalid", {29'd0, if_rvalid | ls_rvalid}, 32'd0);
    check_eq("rst_mem_en", {29'd0, mem_en}, 32'd0);
    check_eq("rst_mem_addr", mem_addr[2], 32'd0);
    check_eq("rst_mem_we", {28'd0, mem_we[2]}, 32'd0);
    rstn = 1'b1;
    step();
    check_eq("rel_ls_first", {31'd0, ls_ready[2]}, 32'd1);
    check_eq("rel_if_wait", {31'd0, if_ready[2]}, 32'd0);
    check_eq("rel_addr", mem_addr[2], 32'h20);
    if_req = 1'b0; ls_req = 1'b0;
    wait_idle();

    if_req = 1'b1; if_addr = 32'h40;
    step();
    check_eq("if2_ready", {31'd0, if_ready[2]}, 32'd1);
    check_eq("if2_mem_en", {31'd0, mem_en[2]}, 32'd1);
    check_eq("if2_addr", mem_addr[2], 32'h40);
    if_req = 1'b0;
    step();
    check_eq("if2_early", {31'd0, if_rvalid[2]}, 32'd0);
    step();
    check_eq("if2_rvalid", {31'd0, if_rvalid[2]}, 32'd1);
    check_eq("if2_rdata", if_rdata[2], 32'h0050_0093);
    step();
    check_eq("if2_done", {30'd0, busy[2], if_rvalid[2]}, 32'd0);
    wait_idle();

    ls_txn_lat1(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 4'hF, 1'b0, 32'd0);
    ls_txn_lat1(1'b1, 32'h100, 32'h1234_5678, 4'h0, 4'h0, 1'b0, 32'd0);
    ls_txn_lat1(1'b0, 32'h100, 32'h0000_0000, 4'hF, 4'h0, 1'b1, 32'hDEAD_BEEF);
    ls_txn_lat1(1'b1, 32'h100, 32'h0000_CAFE, 4'h3, 4'h3, 1'b0, 32'd0);
    ls_txn_lat1(1'b0, 32'h100, 32'h0000_0000, 4'h0, 4'h0, 1'b1, 32'hDEAD_CAFE);

    pulse_reset();
    if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    step();
    check_eq("cf_ls_ready", {30'd0, ls_ready[1], if_ready[1]}, 32'd2);
    ls_req = 1'b0;
    step();
    check_eq("cf_ls_rvalid", {31'd0, ls_rvalid[1]}, 32'd1);
    check_eq("cf_ls_rdata", ls_rdata[1], 32'hDEAD_CAFE);
    step();
    check_eq("cf_if_ready", {30'd0, ls_ready[1], if_ready[1]}, 32'd1);
    check_eq("cf_if_addr", mem_addr[1], 32'h40);
    if_req = 1'b0;
    step();
    check_eq("cf_if_rdata", if_rdata[1], 32'h0050_0093);
    check_eq("cf_if_rvalid", {31'd0, if_rvalid[1]}, 32'd1);
    wait_idle();

`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ls_seq = 3'b101;
`else
    exp_ls_seq = 3'b111;
`endif
    pulse_reset();
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h0; ls_addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("rep_gnt%0d", k), {30'd0, ls_ready[1], if_ready[1]},
               exp_ls_seq[k] ? 32'd2 : 32'd1);
      step();
    end
    if_req = 1'b0; ls_req = 1'b0;
    wait_idle();

    if_req = 1'b1; if_addr = 32'h40;
    step();
    check_eq("rw_ready", {31'd0, if_ready[3]}, 32'd1);
    if_req = 1'b0;
    step();
    check_eq("rw_busy_wait", {31'd0, busy[3]}, 32'd1);
    rstn = 1'b0;
    #1;
    check_eq("rw_async_clear", {29'd0, busy | mem_en}, 32'd0);
    step();
    rstn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | if_rvalid[3] | busy[3];
    end
    check_eq("rw_no_rvalid", {31'd0, seen}, 32'd0);
    if_req = 1'b1; if_addr = 32'h44;
    step();
    check_eq("rw_fresh_ready", {31'd0, if_ready[3]}, 32'd1);
    if_req = 1'b0;
    step(); step(); step();
    check_eq("rw_fresh_rvalid", {31'd0, if_rvalid[3]}, 32'd1);
    check_eq("rw_fresh_rdata", if_rdata[3], 32'hA5A5_0044);
    wait_idle();

    if_req = 1'b1; if_addr = 32'h0; nrdy = 0; nrv = 0;
    for (int c = 1; c <= 14 && (nrdy < 3 || nrv < 3); c++) begin
      step();
      if (if_ready[3]) begin
        check_eq("hold_cycle", c, 1 + 4 * nrdy);
        check_eq("hold_addr", mem_addr[3], 32'(4 * nrdy));
        nrdy++;
        if_addr = 32'(4 * nrdy);
        if (nrdy == 3) if_req = 1'b0;
      end
      if (if_rvalid[3]) begin
        check_eq("hold_rdata", if_rdata[3], 32'hA5A5_0000 | 32'(4 * nrv));
        nrv++;
      end
    end
    check_eq("hold_readies", nrdy, 3);
    check_eq("hold_rvalids", nrv, 3);
    if_req = 1'b0;
    wait_idle();

    check_eq("exclusive", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
